stream_arb_mux: RTL and testbench
=================================

# stream_arb_mux

Registered N-channel arbitrating multiplexer: the parametrised successor of the team's combinational 4:1 data mux. It selects one of `N_CH` valid/ready input streams per cycle, either by arbitration or by a forced select. The winning beat goes into a one-entry output register, tagged with its source channel. It sits between the per-channel producer stages and the single shared downstream consumer.

## Interface

**Parameters**
- `DATA_W`, 32: payload width in bits.
- `N_CH`, 4: number of input channels. Must be at least 2.
- `ARB_MODE`, `ARB_RR`: reset-time arbitration policy (`ARB_FIXED` or `ARB_RR`), of type `arb_mode_e`.
- `CH_W`, derived: `$clog2(N_CH)`. Not overridable.

**Ports**
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, `N_CH`: per-channel beat valid.
- `in_data`, input, `N_CH` x `DATA_W`: per-channel payload, packed array `[N_CH-1:0][DATA_W-1:0]`.
- `in_ready`, output, `N_CH`: per-channel accept. One-hot or zero.
- `force_en`, input, 1: bypass arbitration and use `force_sel`.
- `force_sel`, input, `CH_W`: forced channel index.
- `out_valid`, output, 1: output register holds a beat.
- `out_data`, output, `DATA_W`: registered payload.
- `out_ch`, output, `CH_W`: source channel of `out_data`.
- `out_ready`, input, 1: downstream accept.

## Operation

- **Slot free condition.** `slot_free = !out_valid || out_ready`. A new beat is taken only when `slot_free` is high.
- **Arbitration** (when `force_en` is low):
  - `ARB_FIXED`: the lowest-index channel with `in_valid` high wins.
  - `ARB_RR`: search starts at pointer `rr_ptr` and wraps modulo `N_CH`. The first channel with `in_valid` high wins.
- **Forced select** (when `force_en` is high): the candidate is `force_sel` only. If `in_valid[force_sel]` is low, there is no grant; there is no fallback to other channels. A `force_sel` value of `N_CH` or above also gives no grant.
- **Grant.** `in_ready[g] = slot_free && candidate valid`. All other `in_ready` bits are 0.
- **Handshake.** A transfer on channel g happens when `in_valid[g] && in_ready[g]`. On the next edge `out_data` loads `in_data[g]`, `out_ch` loads g, and `out_valid` goes to 1.
- **Drain.** If `out_valid && out_ready` and there is no new grant, `out_valid` goes to 0. `out_data` and `out_ch` hold their last values.
- **Pointer update.** `rr_ptr` becomes (g+1) mod `N_CH` only on a transfer in RR mode, including forced transfers. It is unchanged when there is no transfer.
- **Stall.** While `out_valid && !out_ready`, the output is stable and all `in_ready` bits are 0.
- **Reset values.** `out_valid` = 0, `out_data` = 0, `out_ch` = 0, `rr_ptr` = 0. `in_ready` = 0 follows because there are no valid inputs during reset.
- **Reset mid-operation.** A held beat is dropped without being signalled. `rr_ptr` returns to 0.

## Timing

- **Latency.** One cycle from the input handshake to `out_valid`.
- **Throughput.** One beat per cycle when `out_ready` is held high. A simultaneous drain and load is a single edge with no bubble.
- **Combinational paths.** `in_ready` depends combinationally on `out_ready`, `out_valid`, `in_valid`, `force_en`, `force_sel` and `rr_ptr`. There is no combinational path from any input to `out_*`.
- **Producer rule.** Producers must keep `in_valid` and `in_data` stable until accepted. The block does not check this.
- **Changing `force_en`.** It may change on any cycle and takes effect in the same cycle's grant.

## Structure

- **Package `mux_pkg`:**
  - `typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e`.
  - Default `DATA_W` and `N_CH` constants.
- **Sub-module `rr_arbiter`** (parameter `N`, `MODE`):
  - Inputs: `req[N]`, `ptr`.
  - Outputs: one-hot `gnt[N]` and encoded `gnt_idx`.
  - Purely combinational.
  - `stream_arb_mux` owns `rr_ptr`, the force override and the output register.

## Test plan

1. **Round-robin cycling.** RR mode, `N_CH`=4, all four channels valid continuously, `out_ready`=1. Required: `out_ch` sequence 0,1,2,3,0,1 on consecutive cycles, `out_data` matches each channel's payload, no bubbles.
2. **Fixed priority.** `ARB_FIXED`, channels 1 and 3 valid with payloads 0x11 and 0x33. Required: channel 1 wins every cycle, `in_ready[3]` = 0 until channel 1 deasserts, then 0x33 appears with `out_ch`=3.
3. **Forced select without fallback.** `force_en`=1, `force_sel`=2, channel 2 invalid and channel 0 valid. Required: `in_ready`=0 and `out_valid` stays 0. When channel 2 is asserted with 0xDEADBEEF, the next cycle shows `out_valid`=1, `out_ch`=2 and that payload.
4. **Backpressure.** `out_ready`=0 for 5 cycles with beat 0xA5A5A5A5 held. Required: `out_data` is stable, `in_ready`=0 throughout. When `out_ready` rises, the next queued beat loads on the same edge as the drain.
5. **Reset mid-operation.** Assert `rst_n` low asynchronously while `out_valid`=1 and `rr_ptr`=2. Required: `out_valid`, `out_data` and `out_ch` go to 0 immediately. After release, the first RR grant with all channels valid goes to channel 0.

Source files
------------

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mux_pkg
// Purpose  : Shared types and defaults for the stream arbitrating multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
package mux_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam int C_DEFAULT_DATA_W = 32;
    localparam int C_DEFAULT_N_CH   = 4;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/stream_arb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational fixed-priority / rotating-priority request arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int        N    = 4,
    parameter arb_mode_e MODE = ARB_RR,
    localparam int       W    = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_any
);

    int w_cand;

    // Walk the channels in priority order; the first requester seen wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        w_cand  = 0;
        for (int i = 0; i < N; i++) begin
            w_cand = (MODE == ARB_RR) ? ((int'(ptr) + i) % N) : i;
            if (!gnt_any && req[w_cand]) begin
                gnt[w_cand] = 1'b1;
                gnt_idx     = W'(w_cand);
                gnt_any     = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/stream_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : stream_arb_mux
// Purpose  : N-channel valid/ready arbitrating mux with a one-entry output
//            register tagged by source channel.
// Revision : 1.0 - initial release
// ============================================================================
module stream_arb_mux
    import mux_pkg::*;
#(
    parameter int        DATA_W   = C_DEFAULT_DATA_W,
    parameter int        N_CH     = C_DEFAULT_N_CH,
    parameter arb_mode_e ARB_MODE = ARB_RR,
    localparam int       CH_W     = $clog2(N_CH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_CH-1:0]                in_valid,
    input  logic [N_CH-1:0][DATA_W-1:0]    in_data,
    output logic [N_CH-1:0]                in_ready,
    input  logic                           force_en,
    input  logic [CH_W-1:0]                force_sel,
    output logic                           out_valid,
    output logic [DATA_W-1:0]              out_data,
    output logic [CH_W-1:0]                out_ch,
    input  logic                           out_ready
);

    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [CH_W-1:0]     r_out_ch;
    logic [CH_W-1:0]     r_rr_ptr;

    logic                w_slot_free;
    logic [N_CH-1:0]     w_arb_gnt;
    logic [CH_W-1:0]     w_arb_idx;
    logic                w_arb_any;
    logic                w_cand_valid;
    logic [CH_W-1:0]     w_cand_idx;
    logic                w_xfer;
    logic [CH_W-1:0]     w_ptr_next;

    assign w_slot_free = !r_out_valid || out_ready;

    rr_arbiter #(
        .N    (N_CH),
        .MODE (ARB_MODE)
    ) u_arb (
        .req     (in_valid),
        .ptr     (r_rr_ptr),
        .gnt     (w_arb_gnt),
        .gnt_idx (w_arb_idx),
        .gnt_any (w_arb_any)
    );

    // A forced select never falls back to another channel, even if idle.
    always_comb begin
        w_cand_valid = 1'b0;
        w_cand_idx   = '0;
        if (force_en) begin
            if ({1'b0, force_sel} < (CH_W+1)'(N_CH)) begin
                w_cand_valid = in_valid[force_sel];
                w_cand_idx   = force_sel;
            end
        end else begin
            w_cand_valid = w_arb_any;
            w_cand_idx   = w_arb_idx;
        end
    end

    assign w_xfer     = w_slot_free && w_cand_valid;
    assign w_ptr_next = (w_cand_idx == CH_W'(N_CH - 1)) ? '0 : (w_cand_idx + CH_W'(1));

    always_comb begin
        in_ready = '0;
        if (w_xfer) begin
            in_ready[w_cand_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= in_data[w_cand_idx];
                r_out_ch    <= w_cand_idx;
                if (ARB_MODE == ARB_RR) begin
                    r_rr_ptr <= w_ptr_next;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

endmodule : stream_arb_mux
`default_nettype wire

// File: tb/tb_stream_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_arb_mux
// Purpose  : Scoreboard bench driving an RR and a FIXED instance in parallel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_arb_mux;
    import mux_pkg::*;

    localparam int N = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [N-1:0]          in_valid = '0;
    logic [N-1:0][31:0]    in_data = '0;
    logic                  force_en = 1'b0;
    logic [1:0]            force_sel = '0;
    logic                  out_ready = 1'b0;

    logic [N-1:0]          rdy_rr, rdy_fx;
    logic                  ov_rr, ov_fx;
    logic [31:0]           od_rr, od_fx;
    logic [1:0]            oc_rr, oc_fx;

    int n_tests = 0;
    int n_fail  = 0;

    logic [33:0] sb0[$];
    logic [33:0] sb1[$];
    bit          held[2];
    int          mptr;

    always #5 clk = ~clk;

    stream_arb_mux #(.DATA_W(32), .N_CH(N), .ARB_MODE(ARB_RR)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_rr), .force_en(force_en), .force_sel(force_sel),
        .out_valid(ov_rr), .out_data(od_rr), .out_ch(oc_rr), .out_ready(out_ready)
    );

    stream_arb_mux #(.DATA_W(32), .N_CH(N), .ARB_MODE(ARB_FIXED)) u_fx (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_fx), .force_en(force_en), .force_sel(force_sel),
        .out_valid(ov_fx), .out_data(od_fx), .out_ch(oc_fx), .out_ready(out_ready)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Winner by the block's rules: forced index only, else lowest index or
    // first valid at/after the pointer (mod N). -1 means no winner.
    function automatic int pick(input logic [N-1:0] v, input bit rr, input int ptr,
                                input bit fen, input int fsel);
        if (fen) return (fsel < N && v[fsel]) ? fsel : -1;
        for (int i = 0; i < N; i++) begin
            int c;
            c = rr ? (ptr + i) % N : i;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Reference model: predicts grants and pushes expected beats.
    always begin
        @(negedge clk);
        #4;
        if (!rst_n) begin
            held[0] = 1'b0;
            held[1] = 1'b0;
            mptr    = 0;
            sb0.delete();
            sb1.delete();
        end else begin
            for (int k = 0; k < 2; k++) begin
                int         g;
                bit         free;
                logic [3:0] exp_rdy;
                g       = pick(in_valid, (k == 0), mptr, force_en, int'(force_sel));
                free    = !held[k] || out_ready;
                exp_rdy = (free && g >= 0) ? (4'b0001 << g) : 4'b0000;
                check(k == 0 ? "rr_in_ready" : "fx_in_ready",
                      64'(k == 0 ? rdy_rr : rdy_fx), 64'(exp_rdy));
                check(k == 0 ? "rr_out_valid" : "fx_out_valid",
                      64'(k == 0 ? ov_rr : ov_fx), 64'(held[k]));
                if (free && g >= 0) begin
                    if (k == 0) begin
                        sb0.push_back({2'(g), in_data[g]});
                        mptr = (g + 1) % N;
                    end else begin
                        sb1.push_back({2'(g), in_data[g]});
                    end
                    held[k] = 1'b1;
                end else if (out_ready) begin
                    held[k] = 1'b0;
                end
            end
        end
    end

    // Monitor: compares every presented output beat with the scoreboard head.
    always begin
        @(negedge clk);
        #4;
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                logic        ov;
                logic [33:0] got;
                ov  = (k == 0) ? ov_rr : ov_fx;
                got = (k == 0) ? {oc_rr, od_rr} : {oc_fx, od_fx};
                if (ov) begin
                    if ((k == 0 ? sb0.size() : sb1.size()) == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL %s_unexpected_beat: got %h, expected none",
                                 k == 0 ? "rr" : "fx", got);
                    end else begin
                        check(k == 0 ? "rr_out_beat" : "fx_out_beat", 64'(got),
                              64'(k == 0 ? sb0[0] : sb1[0]));
                        if (out_ready) begin
                            if (k == 0) void'(sb0.pop_front());
                            else        void'(sb1.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic step(input logic [3:0] v, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        out_ready = ordy;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rr_valid", 64'(ov_rr), 64'd0);
        check("rst_rr_data",  64'(od_rr), 64'd0);
        check("rst_rr_ch",    64'(oc_rr), 64'd0);
        check("rst_fx_valid", 64'(ov_fx), 64'd0);
        check("rst_fx_ready", 64'(rdy_fx), 64'd0);
        check("rst_rr_ready", 64'(rdy_rr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin cycling, all channels valid
        for (int i = 0; i < N; i++) in_data[i] = 32'h1000_0000 + 32'(i);
        repeat (8) step(4'b1111, 1'b1);

        // Fixed priority between channels 1 and 3
        in_data[1] = 32'h11;
        in_data[3] = 32'h33;
        repeat (4) step(4'b1010, 1'b1);
        repeat (3) step(4'b1000, 1'b1);

        // Forced select with no fallback
        @(negedge clk);
        force_en  = 1'b1;
        force_sel = 2'd2;
        repeat (3) step(4'b0001, 1'b1);
        in_data[2] = 32'hDEAD_BEEF;
        repeat (2) step(4'b0101, 1'b1);
        @(negedge clk);
        force_en = 1'b0;

        // Backpressure with a held beat and a queued successor
        in_data[0] = 32'hA5A5_A5A5;
        in_data[1] = 32'h5A5A_5A5A;
        step(4'b0001, 1'b1);
        repeat (5) step(4'b0010, 1'b0);
        repeat (2) step(4'b0010, 1'b1);
        step(4'b0000, 1'b1);

        // Reset mid-operation with rr pointer at 2
        step(4'b0010, 1'b1);
        step(4'b0000, 1'b0);
        #2;
        check("pre_rst_rr_valid", 64'(ov_rr), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_rr_out", 64'({ov_rr, oc_rr, od_rr}), 64'd0);
        check("midrst_fx_out", 64'({ov_fx, oc_fx, od_fx}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #4;
        check("post_rst_rr_grant", 64'(rdy_rr), 64'b0001);
        repeat (3) step(4'b1111, 1'b1);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            in_valid  = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) in_data[i] = $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
            force_en  = ($urandom_range(0, 6) == 0);
            force_sel = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        in_valid  = '0;
        force_en  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #6;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_stream_arb_mux
`default_nettype wire
